// File: rtl/bench_report_tx_pkg.sv
// bench_report_tx_pkg
//   Shared definitions for the benchmark report transmitter. It holds the ASCII
//   constants used by the formatter, the report geometry, the top-level FSM
//   state encodings, and two small formatting helpers.
//   Ports: none (package).
package bench_report_tx_pkg;

    // ASCII constants
    localparam logic [7:0] ASC_C    = 8'h43;  // 'C'
    localparam logic [7:0] ASC_EQ   = 8'h3D;  // '='
    localparam logic [7:0] ASC_B    = 8'h42;  // 'B'
    localparam logic [7:0] ASC_E    = 8'h45;  // 'E'
    localparam logic [7:0] ASC_S    = 8'h53;  // 'S'
    localparam logic [7:0] ASC_T    = 8'h54;  // 'T'
    localparam logic [7:0] ASC_CR   = 8'h0D;
    localparam logic [7:0] ASC_LF   = 8'h0A;
    localparam logic [7:0] ASC_QM   = 8'h3F;  // '?'
    localparam logic [7:0] ASC_0    = 8'h30;  // '0'

    // Report geometry: four 13-byte count lines, then an 8-byte BEST line.
    localparam int REPORT_LEN = 60;
    localparam int LINE_LEN   = 13;
    localparam int NUM_COND   = 4;

    localparam logic [5:0] IDX_LAST  = 6'(REPORT_LEN - 1);
    localparam logic [3:0] COL_LAST  = 4'(LINE_LEN - 1);
    localparam logic [2:0] LINE_BEST = 3'(NUM_COND);

    // Top-level FSM state encodings
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_NEXT = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    // Uppercase hex digit for a nibble.
    function automatic logic [7:0] nib2ascii(input logic [3:0] v);
        if (v < 4'd10) return 8'h30 + {4'h0, v};
        else           return 8'h37 + {4'h0, v};
    endfunction

    // Winner digit; anything that is not exactly one-hot reports '?'.
    function automatic logic [7:0] best2ascii(input logic [3:0] oh);
        case (oh)
            4'b0001: return 8'h30;
            4'b0010: return 8'h31;
            4'b0100: return 8'h32;
            4'b1000: return 8'h33;
            default: return ASC_QM;
        endcase
    endfunction

endpackage

// File: rtl/bench_report_tx_uart_tx_byte.sv
// uart_tx_byte
//   Single-byte 8N1 UART transmitter, LSB first. Owns the baud counter, bit
//   counter and shift register.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     valid      a byte is offered on data
//     data[7:0]  byte to send
//     ready      byte is taken this cycle if valid (also high in the last
//                cycle of a stop bit, so frames can run back-to-back)
//     tx         serial output, idles high
//   CLKS_PER_BIT must be >= 2.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int         CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] BIT_DATA7 = 4'd8;
    localparam logic [3:0] BIT_STOP  = 4'd9;

    logic          r_active;
    logic [CW-1:0] r_baud;
    logic [3:0]    r_bit;     // 0 = start, 1..8 = data, 9 = stop
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_last;

    // Final cycle of the stop bit: a new byte may start on the next edge.
    assign w_last = r_active && (r_bit == BIT_STOP) && (r_baud == BAUD_LAST);
    assign ready  = !r_active || w_last;
    assign tx     = r_tx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else if (valid && ready) begin
            r_active <= 1'b1;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= data;
            r_tx     <= 1'b0;
        end else if (r_active) begin
            if (r_baud == BAUD_LAST) begin
                r_baud <= '0;
                if (r_bit == BIT_STOP) begin
                    r_active <= 1'b0;
                    r_tx     <= 1'b1;
                end else begin
                    r_bit <= r_bit + 4'd1;
                    if (r_bit == BIT_DATA7) begin
                        r_tx <= 1'b1;
                    end else begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end
                end
            end else begin
                r_baud <= r_baud + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bench_report_tx.sv
// bench_report_tx
//   Snapshots a finished benchmark result set and sends it as a 60-byte ASCII
//   report over a UART line (8N1, LSB first):
//     "C0=XXXXXXXX\r\n" .. "C3=XXXXXXXX\r\n" "BEST=n\r\n"
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start           one-cycle pulse, honoured only when idle
//     t_cond0..3      per-condition cycle counts
//     best_onehot     winning condition, one-hot
//     busy            high from the cycle after start is accepted until done
//     done            one-cycle pulse when the last stop bit has completed
//     tx              UART serial output, idles high
module bench_report_tx
    import bench_report_tx_pkg::*;
#(
    parameter int CLK_HZ       = 125_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] t_cond0,
    input  logic [31:0] t_cond1,
    input  logic [31:0] t_cond2,
    input  logic [31:0] t_cond3,
    input  logic [3:0]  best_onehot,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    state_t             r_state;
    state_t             w_next;
    logic [3:0][31:0]   r_t;
    logic [3:0]         r_best;
    logic [5:0]         r_idx;
    logic [2:0]         r_line;
    logic [3:0]         r_col;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_valid;
    logic               w_ready;
    logic [7:0]         w_byte;
    logic [31:0]        w_t;
    logic [3:0]         w_nib;

    // A start in the done cycle is dropped: the block is formally IDLE there,
    // but the report that just ended must not be immediately re-armed.
    assign w_accept = (r_state == ST_IDLE) && start && !r_done;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_valid = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_LOAD;
            ST_LOAD: w_next = ST_SEND;
            ST_SEND: begin
                w_valid = 1'b1;
                if (w_ready) w_next = ST_NEXT;
            end
            ST_NEXT: w_next = (r_idx == IDX_LAST) ? ST_FIN : ST_SEND;
            // Wait for the final frame to reach the end of its stop bit.
            ST_FIN:  if (w_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // ---------------- snapshot, counters, status ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_t    <= '0;
            r_best <= '0;
            r_idx  <= '0;
            r_line <= '0;
            r_col  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (w_accept) begin
                r_t    <= {t_cond3, t_cond2, t_cond1, t_cond0};
                r_best <= best_onehot;
            end
            if (r_state == ST_LOAD) begin
                r_idx  <= '0;
                r_line <= '0;
                r_col  <= '0;
            end else if (r_state == ST_NEXT) begin
                r_idx <= r_idx + 6'd1;
                if (r_col == COL_LAST) begin
                    r_col  <= '0;
                    r_line <= r_line + 3'd1;
                end else begin
                    r_col <= r_col + 4'd1;
                end
            end
            // Registered so busy rises one cycle after acceptance and drops
            // in the same cycle as the done pulse.
            r_busy <= (r_state != ST_IDLE) && (w_next != ST_IDLE);
            r_done <= (r_state == ST_FIN) && (w_next == ST_IDLE);
        end
    end

    assign busy = r_busy;
    assign done = r_done;

    // ---------------- byte formatter ----------------
    // line/col counters track idx/13 and idx%13 without a divider.
    assign w_t = r_t[r_line[1:0]];

    always_comb begin
        w_nib = 4'h0;
        case (r_col)
            4'd3:    w_nib = w_t[31:28];
            4'd4:    w_nib = w_t[27:24];
            4'd5:    w_nib = w_t[23:20];
            4'd6:    w_nib = w_t[19:16];
            4'd7:    w_nib = w_t[15:12];
            4'd8:    w_nib = w_t[11:8];
            4'd9:    w_nib = w_t[7:4];
            4'd10:   w_nib = w_t[3:0];
            default: w_nib = 4'h0;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        if (r_line == LINE_BEST) begin
            case (r_col)
                4'd0:    w_byte = ASC_B;
                4'd1:    w_byte = ASC_E;
                4'd2:    w_byte = ASC_S;
                4'd3:    w_byte = ASC_T;
                4'd4:    w_byte = ASC_EQ;
                4'd5:    w_byte = best2ascii(r_best);
                4'd6:    w_byte = ASC_CR;
                4'd7:    w_byte = ASC_LF;
                default: w_byte = 8'h00;
            endcase
        end else begin
            case (r_col)
                4'd0:    w_byte = ASC_C;
                4'd1:    w_byte = ASC_0 + {5'b0, r_line};
                4'd2:    w_byte = ASC_EQ;
                4'd11:   w_byte = ASC_CR;
                4'd12:   w_byte = ASC_LF;
                default: w_byte = nib2ascii(w_nib);
            endcase
        end
    end

    // ---------------- serialiser ----------------
    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk  (clk),
        .rst  (rst),
        .valid(w_valid),
        .data (w_byte),
        .ready(w_ready),
        .tx   (tx)
    );

endmodule

// File: tb/tb_bench_report_tx.sv
module tb_bench_report_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int TOTAL = 60 * FRAME;   // 2400

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] t0, t1, t2, t3;
    logic [3:0]  best;
    logic        busy, done, tx;

    bench_report_tx #(.CLK_HZ(400), .BAUD(100), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .t_cond0    (t0),
        .t_cond1    (t1),
        .t_cond2    (t2),
        .t_cond3    (t3),
        .best_onehot(best),
        .busy       (busy),
        .done       (done),
        .tx         (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         gap;   // must start exactly one frame after the previous byte
    } exp_t;

    exp_t sb[$];
    int   errs   = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   ncyc = 0;
    int   nbyte = 0;

    task automatic chk(input bit ok, input string name, input string got, input string want);
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL %s: got %s, expected %s", name, got, want);
        end
    endtask

    task automatic push_str(input string s);
        exp_t e;
        for (int i = 0; i < s.len(); i++) begin
            e.b   = s[i];
            e.gap = (i != 0);
            sb.push_back(e);
        end
    endtask

    // ---------------- UART decoder / scoreboard monitor ----------------
    logic [39:0] smp;
    int          mcnt = 0;
    bit          mact = 0;
    int          fst = 0, pst = 0;

    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (done) done_cnt++;
            if (rst) begin
                mact = 0;
                continue;
            end
            if (!mact && tx == 1'b0) begin
                mact = 1;
                mcnt = 0;
                fst  = ncyc;
            end
            if (mact) begin
                smp[mcnt] = tx;
                mcnt++;
                if (mcnt == FRAME) begin
                    logic [7:0] d;
                    bit         shape_ok;
                    exp_t       e;
                    mact = 0;
                    shape_ok = 1;
                    for (int i = 0; i < 8; i++) d[i] = smp[CPB*(i+1)];
                    for (int j = 0; j < 10; j++)
                        for (int q = 0; q < CPB; q++) begin
                            logic w;
                            w = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : smp[CPB*j];
                            if (smp[CPB*j+q] !== w) shape_ok = 0;
                        end
                    if (sb.size() == 0) begin
                        chk(0, "unexpected_byte", $sformatf("0x%02h", d), "no byte");
                    end else begin
                        e = sb.pop_front();
                        chk(shape_ok && d == e.b && (!e.gap || fst == pst + FRAME),
                            $sformatf("byte%0d", nbyte),
                            $sformatf("0x%02h shape=%0d gap=%0d", d, shape_ok, fst - pst),
                            $sformatf("0x%02h shape=1 gap=%0d", e.b, FRAME));
                    end
                    nbyte++;
                    pst = fst;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input logic [31:0] a, b, c, d, input logic [3:0] o);
        t0 = a; t1 = b; t2 = c; t3 = d; best = o;
    endtask

    // Returns one step after the accepting edge N.
    task automatic pulse_start;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < TOTAL + 50; i++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1; break; end
        end
        chk(seen, name, "timeout", "done pulse");
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        #1;
        chk(sb.size() == 0, name, $sformatf("%0d left", sb.size()), "0 left");
    endtask

    task automatic run_report(input string exp, input string name);
        push_str(exp);
        pulse_start();
        wait_done({name, "_done"});
        drain({name, "_drain"});
    endtask

    // ---------------- main sequence ----------------
    string P1, RA, RB, RC;

    initial begin
        int bad, d0;
        bit tx1, tx2, dn;

        P1 = "C0=00000001\r\nC1=0000002A\r\nC2=DEADBEEF\r\nC3=FFFFFFFF\r\n";
        RB = "C0=12345678\r\nC1=9ABCDEF0\r\nC2=00000000\r\nC3=0F0F0F0F\r\nBEST=2\r\n";
        RC = "C0=CAFEF00D\r\nC1=80000000\r\nC2=7FFFFFFF\r\nC3=00C0FFEE\r\nBEST=1\r\n";

        rst = 1'b1; start = 1'b0;
        set_in(32'h0, 32'h0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clk);
        #1;
        chk(tx === 1'b1 && busy === 1'b0 && done === 1'b0, "reset_state",
            $sformatf("tx=%b busy=%b done=%b", tx, busy, done), "tx=1 busy=0 done=0");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Test 1 + 2: content and cycle timing
        set_in(32'h00000001, 32'h0000002A, 32'hDEADBEEF, 32'hFFFFFFFF, 4'b0001);
        RA = {P1, "BEST=0\r\n"};
        push_str(RA);
        pulse_start();
        bad = 0; tx1 = 0; tx2 = 1; dn = 0;
        for (int k = 0; k <= TOTAL + 3; k++) begin
            if (busy !== (k >= 1 && k <= TOTAL + 1)) bad++;
            if (done !== (k == TOTAL + 2)) bad++;
            if (k == 1) tx1 = tx;
            if (k == 2) tx2 = tx;
            if (k == TOTAL + 2) begin dn = done; start = 1'b1; end
            if (k == TOTAL + 3) start = 1'b0;
            @(posedge clk); #1;
        end
        chk(tx1 === 1'b1, "tx_high_N+1", $sformatf("%b", tx1), "1");
        chk(tx2 === 1'b0, "tx_fall_N+2", $sformatf("%b", tx2), "0");
        chk(dn === 1'b1, "done_N+2402", $sformatf("%b", dn), "1");
        chk(bad == 0, "busy_done_window", $sformatf("%0d bad cycles", bad), "0 bad cycles");
        bad = 0;
        repeat (12) begin
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        chk(bad == 0, "start_on_done_ignored", $sformatf("%0d bad cycles", bad), "0 bad cycles");
        drain("t1_drain");

        // Test 3: winner encodings
        set_in(32'h00000001, 32'h0000002A, 32'hDEADBEEF, 32'hFFFFFFFF, 4'b1000);
        run_report({P1, "BEST=3\r\n"}, "best1000");
        best = 4'b0000;
        run_report({P1, "BEST=?\r\n"}, "best0000");
        best = 4'b0110;
        run_report({P1, "BEST=?\r\n"}, "best0110");

        // Test 4: snapshot holds and start while busy is dropped
        set_in(32'h00000001, 32'h0000002A, 32'hDEADBEEF, 32'hFFFFFFFF, 4'b0001);
        push_str(RA);
        d0 = done_cnt;
        pulse_start();
        repeat (2 + 20 * FRAME) @(posedge clk);
        #1;
        set_in(32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0F0F0F0F, 4'b0100);
        pulse_start();
        wait_done("snap_done");
        repeat (50) @(posedge clk);
        #1;
        chk(done_cnt - d0 == 1, "one_done", $sformatf("%0d", done_cnt - d0), "1");
        chk(sb.size() == 0, "snap_drain", $sformatf("%0d left", sb.size()), "0 left");
        run_report(RB, "fresh");

        // Test 5: reset mid-frame
        set_in(32'hCAFEF00D, 32'h80000000, 32'h7FFFFFFF, 32'h00C0FFEE, 4'b0010);
        push_str(RC);
        pulse_start();
        repeat (1 + 30 * FRAME + 5 * CPB) @(posedge clk);
        #1 rst = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;
        chk(tx === 1'b1 && busy === 1'b0 && done === 1'b0, "reset_abort",
            $sformatf("tx=%b busy=%b done=%b", tx, busy, done), "tx=1 busy=0 done=0");
        rst = 1'b0;
        sb.delete();
        repeat (20) @(posedge clk);
        #1;
        chk(done_cnt == d0, "no_done_after_abort", $sformatf("%0d", done_cnt - d0), "0");
        run_report(RC, "after_reset");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected end of sequence");
        $fatal(1, "watchdog");
    end

endmodule
